// File: rtl/i2c_reg_master.sv
// Register-access initiator: turns one register write/read request into a sequence of
// byte commands for a byte-level I2C master engine.
module i2c_reg_master #(
    parameter int ADDR_SIZE_P  = 2,
    parameter int DATA_SIZE_P  = 2,
    parameter bit ENDIANNESS_P = 1'b0
) (
    input  logic                     clk,
    input  logic                     sRst,
    input  logic                     regReq,
    input  logic                     regOp,
    input  logic [6:0]               regDevAddr,
    input  logic [8*ADDR_SIZE_P-1:0] regAddr,
    input  logic [8*DATA_SIZE_P-1:0] regWrData,
    output logic                     regRdy,
    output logic                     regAck,
    output logic                     regFail,
    output logic [8*DATA_SIZE_P-1:0] regRdData,
    output logic                     cmdValid,
    output logic                     cmdStart,
    output logic                     cmdStop,
    output logic                     cmdRead,
    output logic [7:0]               cmdTxData,
    output logic                     cmdMAck,
    input  logic                     cmdDone,
    input  logic                     cmdSlvAck,
    input  logic [7:0]               cmdRxData,
    input  logic                     cmdArbLost
);

    typedef enum logic [2:0] {IDLE, DEV_W, ADDR, DATA_W, DEV_R, DATA_R, DONE} state_t;

    state_t                     state;
    logic [3:0]                 byte_cnt;
    logic                       op_q;
    logic [6:0]                 dev_q;
    logic [8*ADDR_SIZE_P-1:0]   addr_q;
    logic [8*DATA_SIZE_P-1:0]   data_q;
    logic [8*DATA_SIZE_P-1:0]   rd_buf;
    logic [8*DATA_SIZE_P-1:0]   rd_next;
    logic                       last_a, last_d, err;
    logic [2:0]                 a_idx, d_idx;
    logic [7:0]                 addr_byte, data_byte;
    logic                       nx_start, nx_stop, nx_read, nx_mack;
    logic [7:0]                 nx_tx;

    assign last_a = (byte_cnt == 4'(ADDR_SIZE_P - 1));
    assign last_d = (byte_cnt == 4'(DATA_SIZE_P - 1));
    assign a_idx  = ENDIANNESS_P ? 3'(ADDR_SIZE_P - 1) - byte_cnt[2:0] : byte_cnt[2:0];
    assign d_idx  = ENDIANNESS_P ? 3'(DATA_SIZE_P - 1) - byte_cnt[2:0] : byte_cnt[2:0];
    // Slave ACK only means something for bytes we transmitted.
    assign err    = cmdArbLost || (!cmdRead && !cmdSlvAck);

    always_comb begin
        addr_byte = '0;
        data_byte = '0;
        rd_next   = rd_buf;
        for (int i = 0; i < ADDR_SIZE_P; i++) begin
            if (3'(i) == a_idx) addr_byte = addr_q[i*8 +: 8];
        end
        for (int i = 0; i < DATA_SIZE_P; i++) begin
            if (3'(i) == d_idx) begin
                data_byte         = data_q[i*8 +: 8];
                rd_next[i*8 +: 8] = cmdRxData;
            end
        end
    end

    always_comb begin
        nx_start = 1'b0;
        nx_stop  = 1'b0;
        nx_read  = 1'b0;
        nx_mack  = 1'b0;
        nx_tx    = '0;
        case (state)
            DEV_W:   begin nx_start = 1'b1; nx_tx = {dev_q, 1'b0}; end
            ADDR:    nx_tx = addr_byte;
            DATA_W:  begin nx_tx = data_byte; nx_stop = last_d; end
            DEV_R:   begin nx_start = 1'b1; nx_tx = {dev_q, 1'b1}; end
            DATA_R:  begin nx_read = 1'b1; nx_mack = !last_d; nx_stop = last_d; end
            default: ;
        endcase
    end

    // Request fields and partial read word carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && regReq) begin
            op_q   <= regOp;
            dev_q  <= regDevAddr;
            addr_q <= regAddr;
            data_q <= regWrData;
        end
        if (state == DATA_R && cmdValid && cmdDone && !err) rd_buf <= rd_next;
    end

    always_ff @(posedge clk) begin
        if (sRst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            regRdy    <= 1'b1;
            regAck    <= 1'b0;
            regFail   <= 1'b0;
            regRdData <= '0;
            cmdValid  <= 1'b0;
            cmdStart  <= 1'b0;
            cmdStop   <= 1'b0;
            cmdRead   <= 1'b0;
            cmdTxData <= '0;
            cmdMAck   <= 1'b0;
        end else begin
            regAck  <= 1'b0;
            regFail <= 1'b0;
            case (state)
                IDLE: if (regReq) begin
                    state    <= DEV_W;
                    byte_cnt <= '0;
                    regRdy   <= 1'b0;
                end
                DONE: begin
                    state  <= IDLE;
                    regRdy <= 1'b1;
                end
                default:
                    // cmdValid low here is the one-cycle gap after a completed byte.
                    if (!cmdValid) begin
                        cmdValid  <= 1'b1;
                        cmdStart  <= nx_start;
                        cmdStop   <= nx_stop;
                        cmdRead   <= nx_read;
                        cmdTxData <= nx_tx;
                        cmdMAck   <= nx_mack;
                    end else if (cmdDone) begin
                        cmdValid <= 1'b0;
                        if (err) begin
                            state    <= DONE;
                            byte_cnt <= '0;
                            regAck   <= 1'b1;
                            regFail  <= 1'b1;
                        end else begin
                            case (state)
                                DEV_W: begin state <= ADDR; byte_cnt <= '0; end
                                ADDR:
                                    if (last_a) begin
                                        state    <= op_q ? DATA_W : DEV_R;
                                        byte_cnt <= '0;
                                    end else byte_cnt <= byte_cnt + 4'd1;
                                DATA_W:
                                    if (last_d) begin
                                        state    <= DONE;
                                        byte_cnt <= '0;
                                        regAck   <= 1'b1;
                                    end else byte_cnt <= byte_cnt + 4'd1;
                                DEV_R: begin state <= DATA_R; byte_cnt <= '0; end
                                DATA_R:
                                    if (last_d) begin
                                        state     <= DONE;
                                        byte_cnt  <= '0;
                                        regAck    <= 1'b1;
                                        regRdData <= rd_next;
                                    end else byte_cnt <= byte_cnt + 4'd1;
                                default: ;
                            endcase
                        end
                    end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: two instances (LSB-first and MSB-first) run in lockstep against
// a scripted byte engine; command streams and results come from a transaction-level model.
module tb_i2c_reg_master;

    localparam int A = 2;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        sRst, regReq, regOp;
    logic [6:0]  regDevAddr;
    logic [15:0] regAddr, regWrData;
    logic        cmdDone, cmdSlvAck, cmdArbLost;
    logic [7:0]  cmdRxData;

    logic        rdy0, ack0, fail0, cv0, cs0, cp0, cr0, cm0;
    logic [15:0] rd0;
    logic [7:0]  ctx0;
    logic        rdy1, ack1, fail1, cv1, cs1, cp1, cr1, cm1;
    logic [15:0] rd1;
    logic [7:0]  ctx1;

    i2c_reg_master #(.ADDR_SIZE_P(A), .DATA_SIZE_P(D), .ENDIANNESS_P(1'b0)) dut0 (
        .clk(clk), .sRst(sRst), .regReq(regReq), .regOp(regOp), .regDevAddr(regDevAddr),
        .regAddr(regAddr), .regWrData(regWrData), .regRdy(rdy0), .regAck(ack0),
        .regFail(fail0), .regRdData(rd0), .cmdValid(cv0), .cmdStart(cs0), .cmdStop(cp0),
        .cmdRead(cr0), .cmdTxData(ctx0), .cmdMAck(cm0), .cmdDone(cmdDone),
        .cmdSlvAck(cmdSlvAck), .cmdRxData(cmdRxData), .cmdArbLost(cmdArbLost));

    i2c_reg_master #(.ADDR_SIZE_P(A), .DATA_SIZE_P(D), .ENDIANNESS_P(1'b1)) dut1 (
        .clk(clk), .sRst(sRst), .regReq(regReq), .regOp(regOp), .regDevAddr(regDevAddr),
        .regAddr(regAddr), .regWrData(regWrData), .regRdy(rdy1), .regAck(ack1),
        .regFail(fail1), .regRdData(rd1), .cmdValid(cv1), .cmdStart(cs1), .cmdStop(cp1),
        .cmdRead(cr1), .cmdTxData(ctx1), .cmdMAck(cm1), .cmdDone(cmdDone),
        .cmdSlvAck(cmdSlvAck), .cmdRxData(cmdRxData), .cmdArbLost(cmdArbLost));

    always #5 clk = ~clk;

    typedef struct {
        bit        op;
        bit [6:0]  dev;
        bit [15:0] addr;
        bit [15:0] data;
        bit [7:0]  rx0;
        bit [7:0]  rx1;
        int        nack_at;
        int        arb_at;
        int        rst_at;
        int        dly;
        bit        junk;
        bit        exp_fail;
        bit [15:0] exp_rd0;
        bit [15:0] exp_rd1;
    } vec_t;

    vec_t        tbl[8];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_rd0, m_rd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Command as {start, stop, read, mack, tx}; tx ignored on reads, mack ignored on writes.
    function automatic logic [11:0] norm(logic s, logic p, logic r, logic m, logic [7:0] tx);
        return r ? {s, p, r, m, 8'h00} : {s, p, r, 1'b0, tx};
    endfunction

    // k-th bus command of a complete transaction, straight from the framing rules.
    function automatic logic [11:0] exp_cmd(bit op, bit [6:0] dev, bit [15:0] addr,
                                            bit [15:0] data, bit endn, int k);
        int b;
        int pos;
        if (k == 0) return {4'b1000, dev, 1'b0};
        if (k <= A) begin
            b   = k - 1;
            pos = endn ? A - 1 - b : b;
            return {4'b0000, 8'(addr >> (8 * pos))};
        end
        if (op) begin
            b   = k - 1 - A;
            pos = endn ? D - 1 - b : b;
            return {1'b0, b == D - 1, 2'b00, 8'(data >> (8 * pos))};
        end
        if (k == A + 1) return {4'b1000, dev, 1'b1};
        b = k - A - 2;
        return {1'b0, b == D - 1, 1'b1, b != D - 1, 8'h00};
    endfunction

    function automatic bit [15:0] exp_rd(bit [7:0] r0, bit [7:0] r1, bit endn);
        bit [7:0]  r[2];
        bit [15:0] w;
        int        pos;
        r[0] = r0;
        r[1] = r1;
        w    = '0;
        for (int j = 0; j < D; j++) begin
            pos = endn ? D - 1 - j : j;
            w[pos*8 +: 8] = r[j];
        end
        return w;
    endfunction

    task automatic run_txn(input vec_t v, input bit use_tbl);
        int          total, fail_idx, ncmd, n, wait_cnt, k;
        bit          in_cmd, stable, gap_ok, just_done, got_ack, quiet, is_rd;
        logic [11:0] sav0, sav1, cur0, cur1;
        bit          e_fail;
        bit [15:0]   e_rd0, e_rd1;

        total    = v.op ? A + D + 1 : A + D + 2;
        fail_idx = total;
        for (int i = 0; i < total; i++) begin
            is_rd = !v.op && i >= A + 2;
            if (fail_idx == total && (i == v.arb_at || (i == v.nack_at && !is_rd))) fail_idx = i;
        end
        ncmd   = (fail_idx < total) ? fail_idx + 1 : total;
        e_fail = use_tbl ? v.exp_fail : (fail_idx < total);
        e_rd0  = use_tbl ? v.exp_rd0 : ((e_fail || v.op) ? m_rd0 : exp_rd(v.rx0, v.rx1, 1'b0));
        e_rd1  = use_tbl ? v.exp_rd1 : ((e_fail || v.op) ? m_rd1 : exp_rd(v.rx0, v.rx1, 1'b1));

        @(negedge clk);
        check("rdy_idle", {rdy0, rdy1}, 2'b11);
        regReq = 1'b1; regOp = v.op; regDevAddr = v.dev; regAddr = v.addr; regWrData = v.data;
        @(negedge clk);
        regReq = 1'b0;
        check("rdy_busy", {rdy0, rdy1}, 2'b00);

        n = 0; in_cmd = 0; stable = 1; gap_ok = 1; just_done = 0; got_ack = 0; wait_cnt = 0;
        sav0 = '0; sav1 = '0;
        for (int b = 0; b < 400 && !got_ack; b++) begin
            if (b > 0) @(negedge clk);
            cmdDone = 1'b0; cmdSlvAck = 1'b0; cmdArbLost = 1'b0; cmdRxData = 8'h00;
            if (v.junk) begin
                if (b == 1) begin
                    regReq = 1'b1; regOp = ~v.op; regDevAddr = ~v.dev;
                    regAddr = ~v.addr; regWrData = ~v.data;
                end else if (b == 3) regReq = 1'b0;
            end
            if (just_done && (cv0 || cv1)) gap_ok = 0;
            just_done = 0;
            if (ack0) begin
                got_ack = 1;
                check("ack_both", ack1, 1'b1);
                check("fail0", fail0, e_fail);
                check("fail1", fail1, e_fail);
                check("rddata0", rd0, e_rd0);
                check("rddata1", rd1, e_rd1);
            end else if (cv0) begin
                cur0 = norm(cs0, cp0, cr0, cm0, ctx0);
                cur1 = norm(cs1, cp1, cr1, cm1, ctx1);
                if (!in_cmd) begin
                    if (n == v.rst_at) begin
                        sRst = 1'b1;
                        @(negedge clk);
                        sRst = 1'b0;
                        check("rst_cmdvalid", {cv0, cv1}, 2'b00);
                        check("rst_rdy", {rdy0, rdy1}, 2'b11);
                        check("rst_ack", {ack0, ack1}, 2'b00);
                        check("rst_rddata", {rd0, rd1}, 32'h0);
                        quiet = 1;
                        repeat (4) begin
                            @(negedge clk);
                            if (ack0 || ack1 || cv0 || cv1) quiet = 0;
                        end
                        check("rst_quiet", quiet, 1'b1);
                        m_rd0 = '0;
                        m_rd1 = '0;
                        return;
                    end
                    in_cmd = 1; wait_cnt = 0; sav0 = cur0; sav1 = cur1;
                    check("cv1_lockstep", cv1, 1'b1);
                    if (n < ncmd) begin
                        check($sformatf("cmd0_%0d", n), cur0, exp_cmd(v.op, v.dev, v.addr, v.data, 1'b0, n));
                        check($sformatf("cmd1_%0d", n), cur1, exp_cmd(v.op, v.dev, v.addr, v.data, 1'b1, n));
                    end else check("extra_cmd", n, ncmd);
                end else if (cur0 != sav0 || cur1 != sav1) stable = 0;
                if (wait_cnt == v.dly) begin
                    k          = n;
                    is_rd      = !v.op && k >= A + 2;
                    cmdDone    = 1'b1;
                    cmdSlvAck  = (k != v.nack_at);
                    cmdArbLost = (k == v.arb_at);
                    cmdRxData  = (k == A + 2) ? v.rx0 : (is_rd ? v.rx1 : 8'h00);
                    in_cmd = 0; n++; just_done = 1;
                end else wait_cnt++;
            end
        end
        check("ack_seen", got_ack, 1'b1);
        check("cmd_count", n, ncmd);
        check("cmd_stable", stable, 1'b1);
        check("cmd_gap", gap_ok, 1'b1);
        @(negedge clk);
        cmdDone = 1'b0;
        check("post_ack", {ack0, fail0, ack1, fail1}, 4'b0000);
        check("post_rdy", {rdy0, rdy1}, 2'b11);
        check("post_nocmd", {cv0, cv1}, 2'b00);
        m_rd0 = e_rd0;
        m_rd1 = e_rd1;
    endtask

    initial begin
        vec_t v;
        int   r, total;
        tbl[0] = '{1'b1, 7'h6F, 16'h1234, 16'hABCD, 8'h00, 8'h00, -1, -1, -1, 0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 7'h6F, 16'h1234, 16'h0000, 8'h55, 8'hAA, -1, -1, -1, 0, 1'b0, 1'b0, 16'hAA55, 16'h55AA};
        tbl[2] = '{1'b0, 7'h6F, 16'h1234, 16'h0000, 8'h11, 8'h22, 2, -1, -1, 1, 1'b0, 1'b1, 16'hAA55, 16'h55AA};
        tbl[3] = '{1'b0, 7'h6F, 16'h1234, 16'h0000, 8'h33, 8'h44, -1, 3, -1, 0, 1'b0, 1'b1, 16'hAA55, 16'h55AA};
        tbl[4] = '{1'b1, 7'h12, 16'hBEEF, 16'h0F0F, 8'h00, 8'h00, -1, -1, -1, 20, 1'b1, 1'b0, 16'hAA55, 16'h55AA};
        tbl[5] = '{1'b0, 7'h01, 16'h0000, 16'h0000, 8'h00, 8'hFF, -1, -1, -1, 3, 1'b1, 1'b0, 16'hFF00, 16'h00FF};
        tbl[6] = '{1'b0, 7'h6F, 16'h1234, 16'h0000, 8'h77, 8'h88, -1, -1, 4, 0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[7] = '{1'b1, 7'h6F, 16'h1234, 16'hABCD, 8'h00, 8'h00, -1, -1, -1, 0, 1'b0, 1'b0, 16'h0000, 16'h0000};

        sRst = 1'b1; regReq = 1'b0; regOp = 1'b0; regDevAddr = '0; regAddr = '0; regWrData = '0;
        cmdDone = 1'b0; cmdSlvAck = 1'b0; cmdArbLost = 1'b0; cmdRxData = '0;
        repeat (3) @(negedge clk);
        sRst = 1'b0;
        check("reset_rdy", {rdy0, rdy1}, 2'b11);
        check("reset_out", {ack0, fail0, cv0, cs0, cp0, cr0, cm0, ctx0, rd0}, 31'h0);
        m_rd0 = '0;
        m_rd1 = '0;

        cmdDone = 1'b1; cmdSlvAck = 1'b1;
        @(negedge clk);
        cmdDone = 1'b0; cmdSlvAck = 1'b0;
        check("spurious_done", {rdy0, cv0, ack0}, 3'b100);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], 1'b1);

        for (int i = 0; i < 24; i++) begin
            v.op = 1'($urandom); v.dev = 7'($urandom); v.addr = 16'($urandom);
            v.data = 16'($urandom); v.rx0 = 8'($urandom); v.rx1 = 8'($urandom);
            v.nack_at = -1; v.arb_at = -1; v.rst_at = -1;
            v.dly = int'($urandom_range(3, 0)); v.junk = 1'($urandom);
            v.exp_fail = 1'b0; v.exp_rd0 = '0; v.exp_rd1 = '0;
            total = v.op ? A + D + 1 : A + D + 2;
            r = int'($urandom_range(3, 0));
            if (r == 0) v.nack_at = int'($urandom_range(v.op ? A + D : A + 1, 0));
            else if (r == 1) v.arb_at = int'($urandom_range(total - 1, 0));
            run_txn(v, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
